// File: rtl/mm_systolic_q_if.sv
// Operand/result port bundle of the systolic multiplier: per-bank address/data
// lanes, the start/busy/done handshake and the result read port.
interface mm_systolic_q_if #(
    parameter int ROWS_A     = 3,
    parameter int ROWS_B     = 3,
    parameter int INDEX_BITS = 16,
    parameter int BIT_RES    = 32
);
    logic                         start;
    logic                         relu_en;
    logic [INDEX_BITS*ROWS_A-1:0] addr_outA;
    logic [BIT_RES*ROWS_A-1:0]    data_inA;
    logic [INDEX_BITS*ROWS_B-1:0] addr_outB;
    logic [BIT_RES*ROWS_B-1:0]    data_inB;
    logic [INDEX_BITS-1:0]        res_addr;
    logic [BIT_RES-1:0]           res_out;
    logic                         busy;
    logic                         done;
    logic                         sat_flag;

    modport master (
        output start, relu_en, data_inA, data_inB, res_addr,
        input  addr_outA, addr_outB, res_out, busy, done, sat_flag
    );

    modport slave (
        input  start, relu_en, data_inA, data_inB, res_addr,
        output addr_outA, addr_outB, res_out, busy, done, sat_flag
    );
endinterface

// File: rtl/mm_systolic_q.sv
// Output-stationary systolic multiplier C = A*B^T in signed fixed point, with
// per-row operand banks, fixed memory latency, saturating PEs and ReLU readout.
module mm_systolic_q #(
    parameter int ROWS_A     = 3,
    parameter int ROWS_B     = 3,
    parameter int K          = 4,
    parameter int MEM_LAT    = 1,
    parameter int INDEX_BITS = 16,
    parameter int BIT_RES    = 32,
    parameter int FRAC_BITS  = 23
) (
    input logic           clk,
    input logic           reset,
    mm_systolic_q_if.slave bus
);
    localparam int N  = K + ROWS_A + ROWS_B + MEM_LAT - 2;
    localparam int TW = (N > 1) ? $clog2(N) : 1;
    localparam int NC = ROWS_A * ROWS_B;
    localparam int PW = 2 * BIT_RES;
    localparam int SW = 2 * BIT_RES + 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic signed [BIT_RES-1:0] MAX_W = {1'b0, {(BIT_RES-1){1'b1}}};
    localparam logic signed [BIT_RES-1:0] MIN_W = {1'b1, {(BIT_RES-1){1'b0}}};
    localparam logic signed [SW-1:0]      MAX_S = SW'(MAX_W);
    localparam logic signed [SW-1:0]      MIN_S = SW'(MIN_W);

    function automatic logic signed [PW-1:0] q_mul(
        input logic signed [BIT_RES-1:0] a,
        input logic signed [BIT_RES-1:0] b
    );
        logic signed [PW-1:0] wa;
        logic signed [PW-1:0] wb;
        logic signed [PW-1:0] prod;
        wa   = PW'(a);
        wb   = PW'(b);
        prod = wa * wb;
        return prod >>> FRAC_BITS;
    endfunction

    // Returns {clamped, next_acc}.
    function automatic logic [BIT_RES:0] sat_acc(
        input logic signed [BIT_RES-1:0] acc_v,
        input logic signed [PW-1:0]      p
    );
        logic signed [SW-1:0] s;
        s = SW'(acc_v) + SW'(p);
        if (s > MAX_S)
            return {1'b1, MAX_W};
        else if (s < MIN_S)
            return {1'b1, MIN_W};
        else
            return {1'b0, s[BIT_RES-1:0]};
    endfunction

    logic [1:0]                  state;
    logic [TW-1:0]               t;
    logic                        relu_q;
    logic                        sat_q;
    logic                        accept;
    logic [INDEX_BITS*ROWS_A-1:0] addr_a;
    logic [INDEX_BITS*ROWS_B-1:0] addr_b;
    logic [ROWS_A-1:0]           vld_a_p0;
    logic [ROWS_B-1:0]           vld_b_p0;
    logic [ROWS_A-1:0]           vld_a_mem;
    logic [ROWS_B-1:0]           vld_b_mem;
    logic signed [BIT_RES-1:0]   a_in     [ROWS_A][ROWS_B];
    logic signed [BIT_RES-1:0]   b_in     [ROWS_A][ROWS_B];
    logic signed [BIT_RES-1:0]   a_fwd_p1 [ROWS_A][ROWS_B];
    logic signed [BIT_RES-1:0]   b_fwd_p1 [ROWS_A][ROWS_B];
    logic signed [BIT_RES-1:0]   acc      [NC];
    logic [BIT_RES:0]            pe_res   [NC];
    logic                        clamp_any;
    logic signed [BIT_RES-1:0]   rd_val;
    logic signed [BIT_RES-1:0]   res_p1;

    assign accept = (state == S_IDLE) && bus.start;

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= S_IDLE;
            t      <= '0;
            relu_q <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        state  <= S_RUN;
                        t      <= '0;
                        relu_q <= bus.relu_en;
                    end
                end
                S_RUN: begin
                    if (t == TW'(N - 1))
                        state <= S_DONE;
                    else
                        t <= t + 1'b1;
                end
                S_DONE: begin
                    state <= S_IDLE;
                    t     <= '0;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Stage p0: skewed address issue; lane r lags lane 0 by r steps.
    always_comb begin
        int d;
        d        = 0;
        addr_a   = '0;
        addr_b   = '0;
        vld_a_p0 = '0;
        vld_b_p0 = '0;
        if (state == S_RUN) begin
            for (int r = 0; r < ROWS_A; r++) begin
                d = int'(t) - r;
                if (d >= 0 && d < K) begin
                    addr_a[r*INDEX_BITS +: INDEX_BITS] = INDEX_BITS'(d);
                    vld_a_p0[r] = 1'b1;
                end else begin
                    addr_a[r*INDEX_BITS +: INDEX_BITS] = INDEX_BITS'(K);
                end
            end
            for (int c = 0; c < ROWS_B; c++) begin
                d = int'(t) - c;
                if (d >= 0 && d < K) begin
                    addr_b[c*INDEX_BITS +: INDEX_BITS] = INDEX_BITS'(d);
                    vld_b_p0[c] = 1'b1;
                end else begin
                    addr_b[c*INDEX_BITS +: INDEX_BITS] = INDEX_BITS'(K);
                end
            end
        end
    end

    assign bus.addr_outA = addr_a;
    assign bus.addr_outB = addr_b;

    // Valid bits ride alongside the memory so they line up with returning data.
    generate
        if (MEM_LAT == 0) begin : g_lat0
            assign vld_a_mem = vld_a_p0;
            assign vld_b_mem = vld_b_p0;
        end else begin : g_lat
            logic [ROWS_A-1:0] vld_a_sr [MEM_LAT];
            logic [ROWS_B-1:0] vld_b_sr [MEM_LAT];
            always_ff @(posedge clk) begin
                if (reset) begin
                    for (int n = 0; n < MEM_LAT; n++) begin
                        vld_a_sr[n] <= '0;
                        vld_b_sr[n] <= '0;
                    end
                end else begin
                    vld_a_sr[0] <= vld_a_p0;
                    vld_b_sr[0] <= vld_b_p0;
                    for (int n = 1; n < MEM_LAT; n++) begin
                        vld_a_sr[n] <= vld_a_sr[n-1];
                        vld_b_sr[n] <= vld_b_sr[n-1];
                    end
                end
            end
            assign vld_a_mem = vld_a_sr[MEM_LAT-1];
            assign vld_b_mem = vld_b_sr[MEM_LAT-1];
        end
    endgenerate

    // Stage p1: PE array; edge PEs take gated bank data, inner PEs the neighbour's register.
    generate
        for (genvar i = 0; i < ROWS_A; i++) begin : g_row
            for (genvar j = 0; j < ROWS_B; j++) begin : g_col
                if (j == 0) begin : g_edge_a
                    assign a_in[i][j] = vld_a_mem[i] ?
                        $signed(bus.data_inA[i*BIT_RES +: BIT_RES]) : '0;
                end else begin : g_fwd_a
                    assign a_in[i][j] = a_fwd_p1[i][j-1];
                end
                if (i == 0) begin : g_edge_b
                    assign b_in[i][j] = vld_b_mem[j] ?
                        $signed(bus.data_inB[j*BIT_RES +: BIT_RES]) : '0;
                end else begin : g_fwd_b
                    assign b_in[i][j] = b_fwd_p1[i-1][j];
                end
                assign pe_res[i*ROWS_B+j] =
                    sat_acc(acc[i*ROWS_B+j], q_mul(a_in[i][j], b_in[i][j]));
            end
        end
    endgenerate

    always_comb begin
        clamp_any = 1'b0;
        for (int n = 0; n < NC; n++)
            clamp_any = clamp_any | pe_res[n][BIT_RES];
    end

    always_comb begin
        rd_val = '0;
        for (int n = 0; n < NC; n++) begin
            if (bus.res_addr == INDEX_BITS'(n))
                rd_val = acc[n];
        end
        if (relu_q && rd_val[BIT_RES-1])
            rd_val = '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < ROWS_A; i++) begin
                for (int j = 0; j < ROWS_B; j++) begin
                    a_fwd_p1[i][j] <= '0;
                    b_fwd_p1[i][j] <= '0;
                end
            end
            for (int n = 0; n < NC; n++)
                acc[n] <= '0;
            sat_q  <= 1'b0;
            res_p1 <= '0;
        end else begin
            for (int i = 0; i < ROWS_A; i++) begin
                for (int j = 0; j < ROWS_B; j++) begin
                    a_fwd_p1[i][j] <= a_in[i][j];
                    b_fwd_p1[i][j] <= b_in[i][j];
                end
            end
            if (accept) begin
                for (int n = 0; n < NC; n++)
                    acc[n] <= '0;
                sat_q <= 1'b0;
            end else if (state == S_RUN) begin
                for (int n = 0; n < NC; n++)
                    acc[n] <= pe_res[n][BIT_RES-1:0];
                if (clamp_any)
                    sat_q <= 1'b1;
            end
            // Stage p2: registered result read port.
            res_p1 <= rd_val;
        end
    end

    assign bus.res_out  = res_p1;
    assign bus.busy     = (state == S_RUN);
    assign bus.done     = (state == S_DONE);
    assign bus.sat_flag = sat_q;
endmodule

// File: tb/tb_mm_systolic_q.sv
// Bench for mm_systolic_q: two instances (memory latency 1 and 2) fed by a
// latency-accurate bank model, checked against fixed vectors and a C=A*B^T model.
module tb_mm_systolic_q;
    localparam int RA = 3;
    localparam int RB = 3;
    localparam int KK = 3;
    localparam int IB = 16;
    localparam int BR = 32;
    localparam int FB = 23;
    localparam int NC = RA * RB;
    localparam longint QMAX = 2147483647;
    localparam longint QMIN = -QMAX - 1;

    typedef struct {
        logic [IB-1:0] addr;
        logic [BR-1:0] exp;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 reset;
    logic                 start_s [2];
    logic                 relu_s  [2];
    logic [IB-1:0]        raddr_s [2];
    logic [BR-1:0]        res_o   [2];
    logic                 busy_o  [2];
    logic                 done_o  [2];
    logic                 sat_o   [2];
    logic [IB*RA-1:0]     aA_o    [2];
    logic [IB*RB-1:0]     aB_o    [2];
    logic [BR*RA-1:0]     dA_i    [2];
    logic [BR*RB-1:0]     dB_i    [2];
    logic [IB*RA-1:0]     pA      [2][2];
    logic [IB*RB-1:0]     pB      [2][2];
    logic signed [BR-1:0] A_mem   [RA][KK];
    logic signed [BR-1:0] B_mem   [RB][KK];
    logic [BR-1:0]        exp_c   [NC];
    logic                 exp_sat;
    int                   dut_n   [2];
    vec_t                 tab     [11];
    int                   n_checks = 0;
    int                   n_err    = 0;

    mm_systolic_q_if #(.ROWS_A(RA), .ROWS_B(RB), .INDEX_BITS(IB), .BIT_RES(BR)) if0 ();
    mm_systolic_q_if #(.ROWS_A(RA), .ROWS_B(RB), .INDEX_BITS(IB), .BIT_RES(BR)) if1 ();

    mm_systolic_q #(.ROWS_A(RA), .ROWS_B(RB), .K(KK), .MEM_LAT(1), .INDEX_BITS(IB),
                    .BIT_RES(BR), .FRAC_BITS(FB))
        dut0 (.clk(clk), .reset(reset), .bus(if0.slave));
    mm_systolic_q #(.ROWS_A(RA), .ROWS_B(RB), .K(KK), .MEM_LAT(2), .INDEX_BITS(IB),
                    .BIT_RES(BR), .FRAC_BITS(FB))
        dut1 (.clk(clk), .reset(reset), .bus(if1.slave));

    assign if0.start    = start_s[0];
    assign if0.relu_en  = relu_s[0];
    assign if0.res_addr = raddr_s[0];
    assign if0.data_inA = dA_i[0];
    assign if0.data_inB = dB_i[0];
    assign if1.start    = start_s[1];
    assign if1.relu_en  = relu_s[1];
    assign if1.res_addr = raddr_s[1];
    assign if1.data_inA = dA_i[1];
    assign if1.data_inB = dB_i[1];
    assign res_o[0]  = if0.res_out;
    assign busy_o[0] = if0.busy;
    assign done_o[0] = if0.done;
    assign sat_o[0]  = if0.sat_flag;
    assign aA_o[0]   = if0.addr_outA;
    assign aB_o[0]   = if0.addr_outB;
    assign res_o[1]  = if1.res_out;
    assign busy_o[1] = if1.busy;
    assign done_o[1] = if1.done;
    assign sat_o[1]  = if1.sat_flag;
    assign aA_o[1]   = if1.addr_outA;
    assign aB_o[1]   = if1.addr_outB;

    // Bank model: instance u returns data u+1 cycles after the address.
    always @(posedge clk) begin
        for (int u = 0; u < 2; u++) begin
            pA[u][0] <= aA_o[u];
            pA[u][1] <= pA[u][0];
            pB[u][0] <= aB_o[u];
            pB[u][1] <= pB[u][0];
        end
    end

    always_comb begin
        logic [IB-1:0] ad;
        ad = '0;
        for (int u = 0; u < 2; u++) begin
            dA_i[u] = '0;
            dB_i[u] = '0;
            for (int r = 0; r < RA; r++) begin
                ad = pA[u][u][r*IB +: IB];
                if (ad < IB'(KK)) dA_i[u][r*BR +: BR] = A_mem[r][ad[1:0]];
                else              dA_i[u][r*BR +: BR] = 32'hDEADBEEF;
            end
            for (int c = 0; c < RB; c++) begin
                ad = pB[u][u][c*IB +: IB];
                if (ad < IB'(KK)) dB_i[u][c*BR +: BR] = B_mem[c][ad[1:0]];
                else              dB_i[u][c*BR +: BR] = 32'hDEADBEEF;
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic fill(input logic signed [BR-1:0] a, input logic signed [BR-1:0] b);
        for (int r = 0; r < RA; r++)
            for (int k = 0; k < KK; k++) A_mem[r][k] = a;
        for (int c = 0; c < RB; c++)
            for (int k = 0; k < KK; k++) B_mem[c][k] = b;
    endtask

    task automatic load_identity();
        for (int r = 0; r < RA; r++)
            for (int k = 0; k < KK; k++) A_mem[r][k] = (r == k) ? 32'sh00800000 : 32'sh0;
        for (int c = 0; c < RB; c++)
            for (int k = 0; k < KK; k++) B_mem[c][k] = 32'(3 * c + k + 1) <<< FB;
    endtask

    // Reference: C[i][j] accumulated in k order with clamp after every step.
    task automatic model(input logic relu);
        longint acc, p, s;
        exp_sat = 1'b0;
        for (int i = 0; i < RA; i++) begin
            for (int j = 0; j < RB; j++) begin
                acc = 0;
                for (int k = 0; k < KK; k++) begin
                    p = (longint'(A_mem[i][k]) * longint'(B_mem[j][k])) >>> FB;
                    s = acc + p;
                    if (s > QMAX) begin s = QMAX; exp_sat = 1'b1; end
                    else if (s < QMIN) begin s = QMIN; exp_sat = 1'b1; end
                    acc = s;
                end
                if (relu && acc < 0) acc = 0;
                exp_c[i*RB+j] = acc[31:0];
            end
        end
    endtask

    task automatic kick(input int u, input logic relu);
        @(negedge clk);
        start_s[u] = 1'b1;
        relu_s[u]  = relu;
        @(negedge clk);
        start_s[u] = 1'b0;
        relu_s[u]  = 1'b0;
        chk("busy_cycle0", 64'(busy_o[u]), 64'd1);
    endtask

    task automatic run(input int u, input logic relu);
        int dc;
        kick(u, relu);
        dc = -1;
        for (int c = 0; c < 100; c++) begin
            if (done_o[u]) begin
                dc = c;
                break;
            end
            @(negedge clk);
        end
        chk("done_cycle", 64'(dc), 64'(dut_n[u]));
        chk("busy_at_done", 64'(busy_o[u]), 64'd0);
    endtask

    task automatic rd(input int u, input logic [IB-1:0] a, output logic [BR-1:0] v);
        raddr_s[u] = a;
        @(negedge clk);
        v = res_o[u];
    endtask

    task automatic check_const(input int u, input string name, input logic [BR-1:0] val);
        logic [BR-1:0] v;
        for (int n = 0; n < NC; n++) begin
            rd(u, IB'(n), v);
            chk(name, 64'(v), 64'(val));
        end
    endtask

    task automatic check_tab(input int u, input string name);
        logic [BR-1:0] v;
        for (int e = 0; e < 11; e++) begin
            rd(u, tab[e].addr, v);
            chk(name, 64'(v), 64'(tab[e].exp));
        end
        chk({name, "_sat"}, 64'(sat_o[u]), 64'd0);
    endtask

    task automatic check_model(input int u, input string name);
        logic [BR-1:0] v;
        for (int n = 0; n < NC; n++) begin
            rd(u, IB'(n), v);
            chk(name, 64'(v), 64'(exp_c[n]));
        end
        chk({name, "_sat"}, 64'(sat_o[u]), 64'(exp_sat));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int ndone, dcyc;
        int unsigned sha, shb;
        logic relu;
        reset = 1'b1;
        for (int u = 0; u < 2; u++) begin
            start_s[u] = 1'b0;
            relu_s[u]  = 1'b0;
            raddr_s[u] = '0;
        end
        dut_n[0] = KK + RA + RB + 1 - 2;
        dut_n[1] = KK + RA + RB + 2 - 2;
        tab[0]  = '{16'd0,   32'h00800000};
        tab[1]  = '{16'd1,   32'h02000000};
        tab[2]  = '{16'd2,   32'h03800000};
        tab[3]  = '{16'd3,   32'h01000000};
        tab[4]  = '{16'd4,   32'h02800000};
        tab[5]  = '{16'd5,   32'h04000000};
        tab[6]  = '{16'd6,   32'h01800000};
        tab[7]  = '{16'd7,   32'h03000000};
        tab[8]  = '{16'd8,   32'h04800000};
        tab[9]  = '{16'd9,   32'h00000000};
        tab[10] = '{16'd200, 32'h00000000};
        fill(32'sh0, 32'sh0);
        repeat (3) @(negedge clk);

        for (int u = 0; u < 2; u++) begin
            chk("rst_busy", 64'(busy_o[u]), 64'd0);
            chk("rst_done", 64'(done_o[u]), 64'd0);
            chk("rst_sat",  64'(sat_o[u]),  64'd0);
            chk("rst_res",  64'(res_o[u]),  64'd0);
            chk("rst_addrA", 64'(aA_o[u]),  64'd0);
            chk("rst_addrB", 64'(aB_o[u]),  64'd0);
        end
        reset = 1'b0;

        load_identity();
        run(0, 1'b0);
        check_tab(0, "identity");

        fill(32'shFF800000, 32'sh01000000);
        run(0, 1'b0);
        check_const(0, "sign", 32'hFD000000);
        chk("sign_sat", 64'(sat_o[0]), 64'd0);
        run(0, 1'b1);
        check_const(0, "relu", 32'h00000000);

        fill(32'sh3F800000, 32'sh3F800000);
        run(0, 1'b0);
        check_const(0, "saturate", 32'h7FFFFFFF);
        chk("sat_set", 64'(sat_o[0]), 64'd1);
        fill(32'sh0, 32'sh0);
        run(0, 1'b0);
        chk("sat_cleared", 64'(sat_o[0]), 64'd0);
        check_const(0, "zero_run", 32'h00000000);

        load_identity();
        kick(0, 1'b0);
        ndone = 0;
        dcyc  = -1;
        for (int c = 0; c < dut_n[0] + 16; c++) begin
            if (done_o[0]) begin
                ndone++;
                if (dcyc < 0) dcyc = c;
            end
            start_s[0] = (c == 2) || (c == dut_n[0]);
            @(negedge clk);
        end
        start_s[0] = 1'b0;
        chk("ignored_start_done_count", 64'(ndone), 64'd1);
        chk("ignored_start_done_cycle", 64'(dcyc), 64'(dut_n[0]));
        check_tab(0, "ignored_start");

        kick(0, 1'b0);
        repeat (4) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("abort_busy",  64'(busy_o[0]), 64'd0);
        chk("abort_addrA", 64'(aA_o[0]),   64'd0);
        chk("abort_addrB", 64'(aB_o[0]),   64'd0);
        reset = 1'b0;
        check_const(0, "abort_clear", 32'h00000000);
        run(0, 1'b0);
        check_tab(0, "after_abort");

        run(1, 1'b0);
        check_tab(1, "lat2");

        for (int n = 0; n < 8; n++) begin
            sha = $urandom_range(0, 12);
            shb = $urandom_range(0, 12);
            for (int r = 0; r < RA; r++)
                for (int k = 0; k < KK; k++) A_mem[r][k] = $signed($urandom) >>> sha;
            for (int c = 0; c < RB; c++)
                for (int k = 0; k < KK; k++) B_mem[c][k] = $signed($urandom) >>> shb;
            relu = 1'($urandom_range(0, 1));
            model(relu);
            run(n % 2, relu);
            check_model(n % 2, "random");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule

// File: doc/mm_systolic_q.md
# mm_systolic_q

Parametrised output-stationary systolic matrix multiplier computing C = A·Bᵀ in signed Q(BIT_RES−FRAC_BITS−1).FRAC_BITS fixed point. It adds four things to the previous multiplier: a start/busy/done handshake, per-row A banks, a configurable memory read latency, and saturating accumulation with an optional ReLU on readout. It sits between the weight/activation RAM banks and the next layer. It reads operands through address ports and exposes results through a RAM-like read port.

## Interface
- ROWS_A, 3, rows of A; also rows of C.
- ROWS_B, 3, rows of B (stored untransposed); also columns of C.
- K, 4, inner dimension, equal to the column count of both A and B.
- MEM_LAT, 1, cycles from address out to data in, for all banks (≥0).
- INDEX_BITS, 16, address width.
- BIT_RES, 32, word width.
- FRAC_BITS, 23, fractional bits.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- start  in  1  request a multiply; honoured only in IDLE.
- relu_en  in  1  latched on accepted start.
- addr_outA  out  INDEX_BITS*ROWS_A  slice r addresses A bank r (word k = A[r][k]).
- data_inA  in  BIT_RES*ROWS_A  slice r is data from A bank r.
- addr_outB  out  INDEX_BITS*ROWS_B  slice j addresses B bank j (word k = B[j][k]).
- data_inB  in  BIT_RES*ROWS_B  slice j is data from B bank j.
- res_addr  in  INDEX_BITS  result index i*ROWS_B+j.
- res_out  out  BIT_RES  registered result.
- busy  out  1  high in RUN.
- done  out  1  one-cycle pulse when results are final.
- sat_flag  out  1  sticky; set if any accumulation clamped this run.

## Operation
- FSM states are IDLE, RUN and DONE.
  - IDLE→RUN on start.
  - RUN→DONE when the step counter t reaches N−1, where N = K+ROWS_A+ROWS_B+MEM_LAT−2.
  - DONE→IDLE unconditionally.
- On accepted start:
  - clear all accumulators and sat_flag;
  - latch relu_en;
  - set t=0 in the first RUN cycle.
- Addressing in RUN:
  - A slice r = t−r if 0 ≤ t−r < K, else K.
  - B slice j = t−j if 0 ≤ t−j < K, else K.
  - In IDLE and DONE all address slices are 0.
- Per-slice valid bits are delayed by MEM_LAT. Invalid data enters the array as 0, so bank contents at address K are don't-care.
- Array:
  - PE(i,j) forwards A right and B down through one register each.
  - Row i edge takes data_inA slice i; column j edge takes data_inB slice j.
- PE arithmetic:
  - p = (a*b) >>> FRAC_BITS, computed at 2*BIT_RES width (floor rounding).
  - s = acc + p, computed at 2*BIT_RES+1 width.
  - acc ← s clamped to [−2^(BIT_RES−1), 2^(BIT_RES−1)−1]. A clamp sets sat_flag.
- Readout:
  - res_out ← C[res_addr], or 0 if res_addr ≥ ROWS_A*ROWS_B.
  - If relu was latched, negative values read as 0.
  - During RUN the port returns partial sums.
  - Results hold until the next accepted start or reset.
- start in RUN or DONE is ignored; no queueing.

## Timing
- Reset values:
  - state IDLE; t=0;
  - all accumulators and pipeline registers 0;
  - busy=0, done=0, sat_flag=0, res_out=0;
  - all addresses 0; relu latch 0.
- Reset mid-RUN aborts on the next edge and discards all results.
- Start is sampled at edge E. busy rises in cycle 0 (after E), and t=0 issues in cycle 0.
- PE(i,j) consumes element k in cycle k+i+j+MEM_LAT.
- The last accumulation occurs in cycle N−1.
- done=1 and busy=0 in cycle N. Results are final from cycle N.
- res_out latency is 1 cycle from res_addr.
- The first new start is accepted in the cycle after done.

## Test plan
1. Identity. ROWS_A=ROWS_B=K=3, MEM_LAT=1, A=I, B[j][k]=(3j+k+1)·1.0.
   - done in cycle 8.
   - Reading res_addr 1 gives 0x02000000 (4.0); res_addr 8 gives 0x04800000 (9.0).
   - sat_flag=0.
2. Sign and ReLU. A all −1.0, B all 2.0, K=3.
   - With relu_en=0, every res_out = 0xFD000000 (−6.0).
   - Rerun with relu_en=1: every res_out = 0.
3. Saturation. A=B all 127.0 (0x3F800000), K=3.
   - Every res_out = 0x7FFFFFFF; sat_flag=1.
   - The next run with zero operands clears sat_flag.
4. Start ignored. Pulse start again in cycles 2 and N.
   - Exactly one done, in cycle N; results equal the single-run values.
5. Reset mid-run. Assert reset in cycle 4.
   - Next cycle: busy=0, all addresses 0; res_out reads 0 at every address.
   - A fresh start reproduces case 1.
6. Latency and bounds. MEM_LAT=2, case 1 operands.
   - done in cycle 9, same results.
   - res_addr 9 reads 0.
